// File: rtl/shift_seq.sv
// Iterative one-bit-per-cycle shift/rotate unit (LSL, LSR, ASR, ROL) with
// valid/ready handshakes on request and result; carry_out holds the last bit shifted out.
module shift_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       shift_op,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out,
   output logic             busy
);

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [SHW-1:0]   count;
   logic [1:0]       op;
   logic [WIDTH-1:0] step_data;
   logic             step_carry;

   always_comb begin
      state_next   = state;
      start_ready  = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               state_next = (shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (count == SHW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Single-bit step of the datapath for the op latched at acceptance
   always_comb begin
      step_data  = data_out;
      step_carry = carry_out;
      case (op)
         OP_LSL: begin
            step_carry = data_out[WIDTH-1];
            step_data  = {data_out[WIDTH-2:0], 1'b0};
         end
         OP_LSR: begin
            step_carry = data_out[0];
            step_data  = {1'b0, data_out[WIDTH-1:1]};
         end
         OP_ASR: begin
            step_carry = data_out[0];
            step_data  = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
         end
         OP_ROL: begin
            step_carry = data_out[WIDTH-1];
            step_data  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
         end
         default: begin
            step_carry = carry_out;
            step_data  = data_out;
         end
      endcase
   end

   // Reset drops any request in flight; otherwise registers move only per state
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_out  <= '0;
         carry_out <= 1'b0;
         count     <= '0;
         op        <= OP_LSL;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start_valid) begin
                  data_out  <= data_in;
                  op        <= shift_op;
                  count     <= shamt;
                  carry_out <= 1'b0;
               end
            end
            SHIFT: begin
               data_out  <= step_data;
               carry_out <= step_carry;
               count     <= count - SHW'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
